ifetch_req_gen: RTL and testbench

//  Instruction fetch request generator. Issues 64-bit aligned read requests to instruction memory,

---
 rtl/ifetch_req_gen_pkg.sv | 24 ++
 rtl/ifetch_resp_buf.sv | 56 +++++
 rtl/ifetch_req_gen.sv | 102 ++++++++++
 tb/tb_ifetch_req_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_req_gen_pkg.sv
// Shared types and helpers for the instruction fetch request generator and its response buffer.
package ifetch_req_gen_pkg;

  localparam int XLEN    = 64;
  localparam int FETCH_W = 64;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 64'h0000_0000_8000_0000;
  localparam logic [XLEN-1:0] FETCH_STRIDE         = XLEN'(FETCH_W / 8);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [FETCH_W-1:0] data;
  } fetch_word_t;

  // Memory returns the lower address in the low half; downstream wants the first instruction on top.
  function automatic logic [FETCH_W-1:0] half_swap(input logic [FETCH_W-1:0] w);
    return {w[FETCH_W/2-1:0], w[FETCH_W-1:FETCH_W/2]};
  endfunction

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(FETCH_STRIDE - XLEN'(1));
  endfunction

endpackage

// File: rtl/ifetch_resp_buf.sv
// Small FIFO holding fetch words (data + pc) between memory response and downstream consumer.
module ifetch_resp_buf
  import ifetch_req_gen_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_word_t   push_word,
  input  logic          pop,
  input  logic          flush,
  output fetch_word_t   head,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  fetch_word_t   slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = slots[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && !do_pop && count == CW'(DEPTH)));
      if (push)   wr_ptr <= bump(wr_ptr);
      if (do_pop) rd_ptr <= bump(rd_ptr);
      if (push && !do_pop)      count <= count + CW'(1);
      else if (!push && do_pop) count <= count - CW'(1);
    end
  end

  // NOTE: storage is not reset; count gates visibility, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push && !flush) slots[wr_ptr] <= push_word;
  end

endmodule

// File: rtl/ifetch_req_gen.sv
// Instruction fetch request generator: credit-limited aligned requests, in-order response
// buffering, and redirect handling that discards responses still in flight.
module ifetch_req_gen
  import ifetch_req_gen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR    = DEFAULT_RESET_VECTOR,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [XLEN-1:0]    im_req_addr,
  output logic               im_req_valid,
  input  logic               im_req_ready,
  input  logic [FETCH_W-1:0] im_resp_rdata,
  input  logic               im_resp_valid,
  input  logic               if_pc_override,
  input  logic [XLEN-1:0]    if_new_pc,
  output logic [FETCH_W-1:0] f_data,
  output logic [XLEN-1:0]    f_pc,
  output logic               f_valid,
  input  logic               f_ready
);

  localparam int            CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   buf_count;
  logic [CW:0]     credit_used;
  logic            buf_empty;
  logic            req_fire;
  logic            push;
  fetch_word_t     push_word;
  fetch_word_t     head;

  // Counting buffered words as credits guarantees room for every response, so none is ever refused.
  assign credit_used  = {1'b0, outstanding} + {1'b0, buf_count};
  assign im_req_valid = !rst && !if_pc_override && (credit_used < (CW + 1)'(MAX_OUTSTANDING));
  assign im_req_addr  = req_pc;
  assign req_fire     = im_req_valid && im_req_ready;

  assign push           = im_resp_valid && !if_pc_override && (discard == '0);
  assign push_word.pc   = resp_pc;
  assign push_word.data = half_swap(im_resp_rdata);

  assign f_valid = !buf_empty;
  assign f_data  = head.data;
  assign f_pc    = head.pc;

  // NOTE: every output of a combinational block gets a default first, so no latch can be inferred.
  always_comb begin
    outstanding_next = outstanding;
    case ({req_fire, im_resp_valid})
      2'b10:   outstanding_next = outstanding + ONE;
      2'b01:   outstanding_next = outstanding - ONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc      <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      assert (!(im_resp_valid && outstanding == '0));
      assert (discard <= outstanding);
      outstanding <= outstanding_next;
      if (if_pc_override) begin
        // Everything still in flight after this cycle belongs to the old stream.
        req_pc  <= align_pc(if_new_pc);
        resp_pc <= align_pc(if_new_pc);
        discard <= outstanding_next;
      end else begin
        if (req_fire) req_pc  <= req_pc + FETCH_STRIDE;
        if (push)     resp_pc <= resp_pc + FETCH_STRIDE;
        if (im_resp_valid && discard != '0) discard <= discard - ONE;
      end
    end
  end

  ifetch_resp_buf #(
    .DEPTH (MAX_OUTSTANDING),
    .CW    (CW)
  ) u_resp_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_word (push_word),
    .pop       (f_valid && f_ready),
    .flush     (if_pc_override),
    .head      (head),
    .empty     (buf_empty),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_ifetch_req_gen.sv
// Randomized scoreboard bench: a behavioural memory answers requests, the expected fetch stream
// is built from instruction addresses, and a monitor compares every accepted fetch word.
module tb_ifetch_req_gen;

  localparam logic [63:0] RV  = 64'h0000_0000_8000_0000;
  localparam int          MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] im_req_addr;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [63:0] im_resp_rdata;
  logic        im_resp_valid;
  logic        if_pc_override;
  logic [63:0] if_new_pc;
  logic [63:0] f_data;
  logic [63:0] f_pc;
  logic        f_valid;
  logic        f_ready;

  always #5 clk = ~clk;

  ifetch_req_gen #(
    .RESET_VECTOR    (RV),
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .im_req_addr    (im_req_addr),
    .im_req_valid   (im_req_valid),
    .im_req_ready   (im_req_ready),
    .im_resp_rdata  (im_resp_rdata),
    .im_resp_valid  (im_resp_valid),
    .if_pc_override (if_pc_override),
    .if_new_pc      (if_new_pc),
    .f_data         (f_data),
    .f_pc           (f_pc),
    .f_valid        (f_valid),
    .f_ready        (f_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Instruction image: the two words at the reset vector are pinned, the rest is address-derived.
  function automatic logic [31:0] instr_at(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 32'h2222_2222;
    if (a == 64'h0000_0000_8000_0004) return 32'h1111_1111;
    return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct { logic [63:0] pc; logic [63:0] data; } exp_t;
  typedef struct { logic [63:0] addr; int due; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend[$];
  logic [63:0] next_pc;
  logic [63:0] base;
  bit          flush_now;
  int          n_acc  = 0;
  int          n_resp = 0;
  int          tb_out = 0;
  int          ready_pct = 100;
  int          min_lat = 1;
  int          max_lat = 1;

  // Memory model: in-order responses after a random latency, memory reset together with the DUT.
  initial begin
    int          cyc;
    int          last_due;
    int          lat;
    int          due;
    logic [63:0] exp_req;
    cyc = 0; last_due = 0; exp_req = RV;
    im_req_ready = 1'b0; im_resp_valid = 1'b0; im_resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
        tb_out   = 0;
        exp_req  = RV;
        last_due = cyc;
      end else begin
        if (im_resp_valid) begin
          tb_out--;
          n_resp++;
        end
        if (im_req_valid && im_req_ready) begin
          check("req_addr", im_req_addr, exp_req);
          exp_req += 64'd8;
          tb_out++;
          check("req_credit", 64'(tb_out <= MAX), 64'd1);
          lat = $urandom_range(max_lat, min_lat);
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{im_req_addr, due});
        end
        if (if_pc_override) begin
          check("req_valid_in_redirect", 64'(im_req_valid), 64'd0);
          exp_req = if_new_pc & ~64'h7;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      im_req_ready = ($urandom_range(99, 0) < ready_pct);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        im_resp_valid = 1'b1;
        im_resp_rdata = {instr_at(pend[0].addr + 64'd4), instr_at(pend[0].addr)};
        void'(pend.pop_front());
      end else begin
        im_resp_valid = 1'b0;
        im_resp_rdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor: every accepted fetch word must be the next word of the current expected stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (f_valid && f_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL f_word: got pc %h, expected no word", f_pc);
        end else begin
          e = exp_q.pop_front();
          check("f_pc", f_pc, e.pc);
          check("f_data", f_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (flush_now) begin
      exp_q.delete();
      next_pc   = base;
      flush_now = 1'b0;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back('{next_pc, {instr_at(next_pc), instr_at(next_pc + 64'd4)}});
      next_pc += 64'd8;
    end
  endtask

  task automatic run(input int n, input int fr_pct);
    repeat (n) begin
      f_ready = ($urandom_range(99, 0) < fr_pct);
      tick();
    end
  endtask

  task automatic redirect(input logic [63:0] pc);
    if_pc_override = 1'b1;
    if_new_pc      = pc;
    base           = pc & ~64'h7;
    flush_now      = 1'b1;
    tick();
    if_pc_override = 1'b0;
    if_new_pc      = {$urandom, $urandom};
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    base      = RV;
    flush_now = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic expect_progress(input string name, input int since, input int min_words);
    check(name, 64'(n_acc - since >= min_words), 64'd1);
  endtask

  initial begin
    int acc0;
    bit got;
    rst = 1'b1; if_pc_override = 1'b0; if_new_pc = '0; f_ready = 1'b1;
    base = RV; next_pc = RV; flush_now = 1'b1;

    // Reset state and first request.
    tick(); tick();
    @(negedge clk);
    check("rst_req_valid", 64'(im_req_valid), 64'd0);
    check("rst_f_valid", 64'(f_valid), 64'd0);
    check("rst_req_addr", im_req_addr, RV);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", 64'(im_req_valid), 64'd1);
    check("first_req_addr", im_req_addr, RV);
    tick();

    // Streaming with an always-ready, single-cycle memory.
    acc0 = n_acc;
    run(20, 100);
    expect_progress("p1_progress", acc0, 5);

    // Downstream stall: buffer fills to the credit limit and requests stop.
    f_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("stall_req_valid", 64'(im_req_valid), 64'd0);
    check("stall_in_flight", 64'(tb_out), 64'd0);
    check("stall_buffered", 64'(n_resp - n_acc), 64'(MAX));
    tick();
    acc0 = n_acc;
    run(20, 100);
    expect_progress("p2_progress", acc0, 5);

    // Redirect with the maximum number of requests in flight.
    min_lat = 3; max_lat = 3;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = (tb_out == MAX);
    end
    check("p3_full_in_flight", 64'(got), 64'd1);
    redirect(64'h0000_0000_8000_0104);
    acc0 = n_acc;
    run(20, 100);
    expect_progress("p3_progress", acc0, 3);

    // Redirects landing on cycles with responses and request attempts in progress.
    min_lat = 1; max_lat = 1;
    for (int k = 0; k < 4; k++) begin
      run(k + 3, 100);
      redirect(64'h0000_0000_9000_0000 + 64'(k * 64));
    end
    acc0 = n_acc;
    run(20, 100);
    expect_progress("p4_progress", acc0, 5);

    // Back-to-back redirects, then a stream that wraps the address space.
    redirect(64'h0000_0000_0000_1000);
    redirect(64'h0000_0000_0000_2000);
    acc0 = n_acc;
    run(20, 100);
    expect_progress("p5_progress", acc0, 5);
    redirect(64'hFFFF_FFFF_FFFF_FFF5);
    acc0 = n_acc;
    run(20, 100);
    expect_progress("wrap_progress", acc0, 5);

    // Random memory readiness, latency, downstream readiness, redirects and a mid-stream reset.
    ready_pct = 60; min_lat = 1; max_lat = 4;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(2);
      else if ($urandom_range(99, 0) < 4) redirect({$urandom, $urandom});
      else run(1, 70);
    end
    ready_pct = 100; min_lat = 1; max_lat = 1;
    acc0 = n_acc;
    run(40, 100);
    expect_progress("p6_progress", acc0, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
